booth_pp_issuer: RTL and testbench
==================================

# booth_pp_issuer

Radix-4 Booth partial-product issuer: the producer that feeds the 8-input carry-save compressor tree. Accepts one multiplicand/multiplier pair per transaction over a valid/ready handshake, Booth-recodes the multiplier, and streams the resulting partial-product rows to the tree in beats of 8 rows. Each row is full two's complement and 2*WIDTH wide, so the modular sum of all rows over all beats equals the product.

## Interface
- WIDTH, 32, operand width; must be even and ≥ 4
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  issuer can accept an operand pair
- a_i  in  WIDTH  multiplicand
- b_i  in  WIDTH  multiplier
- signed_i  in  1  1: a_i and b_i are two's complement; 0: unsigned
- pp_valid  out  1  pp_o holds a valid beat
- pp_ready  in  1  tree accepts the beat
- pp_o  out  8 x 2*WIDTH  unpacked array of partial-product rows
- pp_beat  out  $clog2(BEATS)  index of the current beat, 0-based; 1 bit when BEATS is 1
- pp_last  out  1  current beat is the final one of the transaction

## Operation
- Derived constants: N = WIDTH/2+1 Booth digits, BEATS = ceil(N/8); WIDTH=32 gives N=17 and BEATS=3.
- Multiplier extension: b_ext = {2 ext bits, b_i, 1'b0}. The ext bits are b_i[WIDTH-1] when signed_i=1, otherwise 0.
- Digit j = -2*b_ext[2j+2] + b_ext[2j+1] + b_ext[2j], with value in {-2,-1,0,+1,+2}, for j = 0..N-1.
- Multiplicand extension: a_ext = a_i sign-extended (signed_i=1) or zero-extended to 2*WIDTH.
- Row j = (digit_j * a_ext) << 2j, truncated to 2*WIDTH. Negation is a full two's-complement negate inside the row; no separate +1 correction rows.
- Beat k carries rows 8k..8k+7 on pp_o[0..7]. Row indices ≥ N are driven to all-zero.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch a_ext, b_ext and signed_i, set beat=0, go to ISSUE.
  - ISSUE: pp_valid=1. On pp_ready: if pp_last, go to IDLE; otherwise beat+1.
- in_ready is 0 in ISSUE. There is no overlap between transactions.
- pp_o, pp_beat and pp_last stay stable while pp_valid=1 and pp_ready=0.
- Reset mid-transaction abandons the current product; no partial beat is emitted afterwards.

## Timing
- Reset values: state=IDLE, in_ready=1, pp_valid=0, pp_beat=0, pp_last=0, pp_o=all-zero.
- Operand accepted at edge t; first beat is valid from edge t+1 (one-cycle latency). All outputs are registered.
- Zero back-pressure: BEATS consecutive cycles of pp_valid, then one IDLE cycle before the next transaction can be accepted.
- Transaction throughput: one product per BEATS+1 cycles.
- pp_last=1 exactly when pp_beat is the final beat.

## Configuration
- BOOTH_PP_ZERO_SKIP_EN defined: in ISSUE, any non-final beat whose 8 digits are all zero is skipped without being presented. pp_beat still reports the true beat index, so the tree may see gaps. The final beat is always presented, even if all-zero, so that pp_last is delivered. Skip evaluation uses the latched b_ext; the state advances in the same cycle a skip is taken.
- BOOTH_PP_ZERO_SKIP_EN undefined: every beat 0..BEATS-1 is presented in order.

## Structure
- Shared package booth_pkg holds:
  - typedef enum for the digit encoding: ZERO, POS1, POS2, NEG1, NEG2
  - ROWS_PER_BEAT=8
  - functions computing N and BEATS from WIDTH
- One sub-module, booth_row_gen (combinational): inputs are a 3-bit triplet, a_ext and the row shift; output is one 2*WIDTH row. booth_pp_issuer instantiates it 8 times, indexed by beat.

## Test plan
All scenarios use WIDTH=32.
- Unsigned a=3, b=5. Beat 0 has pp_o[0]=3, pp_o[1]=12, all other rows 0. Beats 1–2 are all-zero; beat 2 has pp_last=1. Row sum = 15.
- Signed a=-1, b=-1. Beat 0 has pp_o[0]=64'h1, all other rows 0. Row sum mod 2^64 = 1.
- Unsigned a=b=32'hFFFFFFFF. Row sum over 3 beats = 64'hFFFFFFFE00000001. Signed a=32'h80000000, b=32'h80000000 gives row sum 64'h4000000000000000.
- pp_ready held low 5 cycles on beat 1. pp_o, pp_beat=1 and pp_valid stay constant throughout. Raising pp_ready advances to beat 2 on the next edge. in_ready stays 0 until the edge after the beat 2 handshake.
- rst asserted during beat 1. pp_valid and pp_last drop to 0 and in_ready rises to 1 immediately. The next transaction (a=2, b=3) produces row sum 6 starting at beat 0.
- b=0 with BOOTH_PP_ZERO_SKIP_EN defined: a single beat with pp_beat=2, pp_last=1 and all rows zero. Without the macro: three all-zero beats.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth partial-product issuer:
// digit encoding, issuer FSM states, beat geometry and the triplet decoder.
package booth_pkg;

    typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_t;

    typedef enum logic {IDLE, ISSUE} issue_state_t;

    localparam int ROWS_PER_BEAT = 8;

    // Booth digits needed to cover a WIDTH-bit multiplier plus its extension
    function automatic int num_digits(input int width);
        return width / 2 + 1;
    endfunction

    // Beats of ROWS_PER_BEAT rows needed to carry every digit
    function automatic int num_beats(input int width);
        return (num_digits(width) + ROWS_PER_BEAT - 1) / ROWS_PER_BEAT;
    endfunction

    // Triplet {b[2j+2], b[2j+1], b[2j]} to digit -2*b2 + b1 + b0
    function automatic booth_digit_t booth_decode(input logic [2:0] t);
        case (t)
            3'b001, 3'b010: return POS1;
            3'b011:         return POS2;
            3'b100:         return NEG2;
            3'b101, 3'b110: return NEG1;
            default:        return ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_row_gen.sv
// One Booth partial-product row: digit(trip) * a_ext, shifted left by
// 'shift' and truncated to 2*WIDTH. Negative digits are fully negated here,
// so the row is a complete two's-complement value.
module booth_row_gen
    import booth_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 7
) (
    input  logic [2:0]         trip,
    input  logic [2*WIDTH-1:0] a_ext,
    input  logic [SHW-1:0]     shift,
    output logic [2*WIDTH-1:0] row
);

    logic [2*WIDTH-1:0] mag;

    // Select the digit multiple of the multiplicand, then place it
    always_comb begin
        mag = '0;
        case (booth_decode(trip))
            POS1:    mag = a_ext;
            POS2:    mag = {a_ext[2*WIDTH-2:0], 1'b0};
            NEG1:    mag = -a_ext;
            NEG2:    mag = -{a_ext[2*WIDTH-2:0], 1'b0};
            default: mag = '0;
        endcase
        row = mag << shift;
    end

endmodule

// File: rtl/booth_pp_issuer.sv
// Radix-4 Booth partial-product issuer feeding an 8-input CSA tree.
// Accepts one operand pair, then streams BEATS beats of 8 rows each.
// Optional feature macro: BOOTH_PP_ZERO_SKIP_EN -- skip non-final beats
// whose digits are all zero (pp_beat still reports the true index).
module booth_pp_issuer
    import booth_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int BEATS = num_beats(WIDTH),
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               signed_i,
    output logic               pp_valid,
    input  logic               pp_ready,
    output logic [2*WIDTH-1:0] pp_o [ROWS_PER_BEAT],
    output logic [BW-1:0]      pp_beat,
    output logic               pp_last
);

    localparam int N   = num_digits(WIDTH);
    localparam int BXW = WIDTH + 3;                // {2 ext, b, 1'b0}
    localparam int SHW = $clog2(2 * WIDTH + 32);   // holds 2*(8*BEATS-1)
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    issue_state_t       state_q, state_d;
    logic [2*WIDTH-1:0] a_q, a_in, a_src;
    logic [BXW-1:0]     b_q, b_in, b_src;
    logic [BW-1:0]      cand, beat_d;
    logic [2:0]         trip  [ROWS_PER_BEAT];
    logic [SHW-1:0]     shamt [ROWS_PER_BEAT];
    logic [2*WIDTH-1:0] rows  [ROWS_PER_BEAT];
    logic               vld_d, last_d, rdy_d;
    logic               accept;

    assign accept = (state_q == IDLE) && in_valid;

    // Operand extension; on the accept cycle rows are built from the fresh
    // operands so the first beat is registered one cycle after the handshake
    always_comb begin
        a_in  = signed_i ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
        b_in  = {{2{signed_i & b_i[WIDTH-1]}}, b_i, 1'b0};
        a_src = (state_q == IDLE) ? a_in : a_q;
        b_src = (state_q == IDLE) ? b_in : b_q;
    end

`ifdef BOOTH_PP_ZERO_SKIP_EN
    logic [BEATS-1:0] zero_beat;

    // Flag beats whose digits are all zero (triplet 000 or 111)
    always_comb begin
        zero_beat = '1;
        for (int j = 0; j < N; j++) begin
            if (b_src[2*j +: 3] != 3'b000 && b_src[2*j +: 3] != 3'b111)
                zero_beat[j / ROWS_PER_BEAT] = 1'b0;
        end
    end
`endif

    // Next-state logic: handshake-driven state and candidate beat
    always_comb begin
        state_d = state_q;
        cand    = pp_beat;
        case (state_q)
            IDLE: begin
                cand = '0;
                if (in_valid) state_d = ISSUE;
            end
            ISSUE: begin
                if (pp_ready) begin
                    if (pp_last) begin
                        state_d = IDLE;
                        cand    = '0;
                    end else begin
                        cand = pp_beat + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat to present next; with skipping, jump to the first non-zero beat
    // at or after the candidate, falling back to the final beat
    always_comb begin
`ifdef BOOTH_PP_ZERO_SKIP_EN
        logic found;
        found  = 1'b0;
        beat_d = LAST;
        for (int k = 0; k < BEATS; k++) begin
            if (!found && k >= int'(cand) && (k == BEATS - 1 || !zero_beat[k])) begin
                beat_d = BW'(k);
                found  = 1'b1;
            end
        end
        if (state_d != ISSUE) beat_d = '0;
`else
        beat_d = (state_d == ISSUE) ? cand : '0;
`endif
    end

    // Triplet and shift for each row slot of the selected beat
    always_comb begin
        for (int r = 0; r < ROWS_PER_BEAT; r++) begin
            int j, jj;
            j        = int'(beat_d) * ROWS_PER_BEAT + r;
            jj       = (j < N) ? j : 0;
            trip[r]  = (j < N) ? b_src[2*jj +: 3] : 3'b000;
            shamt[r] = SHW'(2 * j);
        end
    end

    for (genvar r = 0; r < ROWS_PER_BEAT; r++) begin : g_row
        booth_row_gen #(
            .WIDTH (WIDTH),
            .SHW   (SHW)
        ) u_row (
            .trip  (trip[r]),
            .a_ext (a_src),
            .shift (shamt[r]),
            .row   (rows[r])
        );
    end

    // Output logic: next values of the registered handshake flags
    always_comb begin
        vld_d  = (state_d == ISSUE);
        last_d = vld_d && (beat_d == LAST);
        rdy_d  = (state_d == IDLE);
    end

    // State and registered outputs; reset drops any in-flight product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            in_ready <= 1'b1;
            pp_valid <= 1'b0;
            pp_beat  <= '0;
            pp_last  <= 1'b0;
            for (int r = 0; r < ROWS_PER_BEAT; r++) pp_o[r] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q <= a_in;
                b_q <= b_in;
            end
            in_ready <= rdy_d;
            pp_valid <= vld_d;
            pp_beat  <= beat_d;
            pp_last  <= last_d;
            for (int r = 0; r < ROWS_PER_BEAT; r++) pp_o[r] <= vld_d ? rows[r] : '0;
        end
    end

endmodule

// File: tb/tb_booth_pp_issuer.sv
// Directed + random bench for booth_pp_issuer (WIDTH=32) with a beat
// scoreboard and a per-transaction row-sum check against the true product.
module tb_booth_pp_issuer;
    import booth_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        signed_i = 1'b0;
    logic        pp_ready = 1'b1;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        in_ready, pp_valid, pp_last;
    logic [63:0] pp_o [8];
    logic [1:0]  pp_beat;

    booth_pp_issuer #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_i      (a_i),
        .b_i      (b_i),
        .signed_i (signed_i),
        .pp_valid (pp_valid),
        .pp_ready (pp_ready),
        .pp_o     (pp_o),
        .pp_beat  (pp_beat),
        .pp_last  (pp_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] r [8];
        logic [1:0]  beat;
        logic        last;
    } exp_t;

    exp_t        q  [$];
    logic [63:0] sq [$];
    logic [63:0] acc = '0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint ext(input logic [31:0] v, input logic s);
        return s ? longint'($signed(v)) : longint'(v);
    endfunction

    // Build expected beats from digit arithmetic and queue the product
    task automatic push_txn(input logic [31:0] a, input logic [31:0] b, input logic s,
                            input logic [63:0] prod);
        logic [34:0] be;
        longint      ae;
        be = {{2{s & b[31]}}, b, 1'b0};
        ae = ext(a, s);
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            logic nz;
            nz = 1'b0;
            for (int r = 0; r < 8; r++) begin
                int j, d;
                j = 8 * k + r;
                e.r[r] = '0;
                if (j < 17) begin
                    d = -2 * int'(be[2*j+2]) + int'(be[2*j+1]) + int'(be[2*j]);
                    if (d != 0) nz = 1'b1;
                    e.r[r] = 64'((longint'(d) * ae) << (2 * j));
                end
            end
            e.beat = 2'(k);
            e.last = (k == 2);
`ifdef BOOTH_PP_ZERO_SKIP_EN
            if (nz || k == 2) q.push_back(e);
`else
            q.push_back(e);
`endif
        end
        sq.push_back(prod);
    endtask

    // Compare a beat at the negedge before it is handshaken
    task automatic monitor();
        if (pp_valid === 1'b1 && pp_ready) begin
            total++;
            assert (q.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_beat observed=%0d expected=none", pp_beat);
            end
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                for (int i = 0; i < 8; i++) begin
                    chk($sformatf("row%0d_beat%0d", i, e.beat), pp_o[i], e.r[i]);
                    acc += pp_o[i];
                end
                chk("pp_beat", 64'(pp_beat), 64'(e.beat));
                chk("pp_last", 64'(pp_last), 64'(e.last));
                if (e.last && sq.size() > 0) begin
                    chk("row_sum", acc, sq.pop_front());
                    acc = '0;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] prod);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("in_ready_wait", 64'(in_ready), 64'd1);
        push_txn(a, b, s, prod);
        a_i = a; b_i = b; signed_i = s; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_pp_valid", 64'(pp_valid), 64'd0);
        chk("rst_pp_beat",  64'(pp_beat),  64'd0);
        chk("rst_pp_last",  64'(pp_last),  64'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("rst_row%0d", i), pp_o[i], 64'd0);
        rst = 1'b0;
        step();

        // directed products
        send(32'd3, 32'd5, 1'b0, 64'd15);                         drain();
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'd1);            drain();
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001); drain();
        send(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000); drain();

        // back-to-back random products
        for (int t = 0; t < 6; t++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            send(ra, rb, rs, 64'(ext(ra, rs) * ext(rb, rs)));
        end
        drain();

        // back-pressure held on beat 1
        send(32'h12345678, 32'h87654321, 1'b0, 64'h12345678 * 64'h87654321);
        step();
        pp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("stall_valid", 64'(pp_valid), 64'd1);
            chk("stall_beat",  64'(pp_beat),  64'd1);
            chk("stall_ready", 64'(in_ready), 64'd0);
            if (q.size() > 0)
                for (int i = 0; i < 8; i++) chk($sformatf("stall_row%0d", i), pp_o[i], q[0].r[i]);
        end
        pp_ready = 1'b1;
        step();
        chk("post_stall_beat",  64'(pp_beat),  64'd2);
        chk("post_stall_ready", 64'(in_ready), 64'd0);
        step();
        chk("after_last_ready", 64'(in_ready), 64'd1);
        drain();

        // reset during beat 1
        send(32'h0000_1234, 32'h7FFF_FFFF, 1'b0, 64'h1234 * 64'h7FFFFFFF);
        step();
        chk("pre_rst_beat", 64'(pp_beat), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(pp_valid), 64'd0);
        chk("mid_rst_last",  64'(pp_last),  64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        q.delete();
        sq.delete();
        acc = '0;
        step();
        rst = 1'b0;
        send(32'd2, 32'd3, 1'b0, 64'd6);
        drain();

        // zero multiplier: one final beat when skipping, else three zero beats
        send(32'd123, 32'd0, 1'b0, 64'd0);
        drain();
        step();
        chk("idle_valid", 64'(pp_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
